// File: rtl/div_sched.sv
// Oldest-first scheduler for the shared non-pipelined divider; owns the unit from pick to writeback.
// Optional build macro DIV_SCHED_B2B_EN: re-pick in WB to remove the idle bubble between divides.
module div_sched #(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCOMMIT-1:0]  ready_mask,
  input  logic [LNCOMMIT-1:0] commit_head,
  input  logic [NCOMMIT-1:0]  kill,
  output logic                issue_valid,
  output logic [LNCOMMIT-1:0] issue_idx,
  input  logic                issue_ack,
  input  logic                div_done,
  output logic                div_abort,
  output logic                wb_valid,
  output logic [LNCOMMIT-1:0] wb_idx,
  input  logic                wb_stall,
  output logic [NCOMMIT-1:0]  picked,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RUN  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // Rotate right so the commit head lands at bit 0 (oldest first).
  function automatic logic [NCOMMIT-1:0] rot_right(input logic [NCOMMIT-1:0] v,
                                                   input logic [LNCOMMIT-1:0] sh);
    logic [2*NCOMMIT-1:0] dbl;
    dbl = {v, v} >> sh;
    return dbl[NCOMMIT-1:0];
  endfunction

  function automatic logic [LNCOMMIT-1:0] lowest_set(input logic [NCOMMIT-1:0] v);
    logic [LNCOMMIT-1:0] idx;
    idx = {LNCOMMIT{1'b0}};
    for (int i = NCOMMIT - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = LNCOMMIT'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t              state_r;
  state_t              state_nxt_s;
  logic [LNCOMMIT-1:0] idx_r;
  logic [LNCOMMIT-1:0] idx_nxt_s;
  logic                abort_nxt_s;
  logic                issue_valid_r;
  logic                div_abort_r;
  logic                wb_valid_r;
  logic                busy_r;

  logic [NCOMMIT-1:0]  cand_s;
  logic [NCOMMIT-1:0]  rot_s;
  logic                pick_any_s;
  logic [LNCOMMIT-1:0] pick_slot_s;
  logic [NCOMMIT-1:0]  pick_oh_s;
  logic                pick_en_s;
  logic                kill_cur_s;

  // Age-ordered pick among ready, non-killed slots.
  always_comb begin
    cand_s      = ready_mask & ~kill;
    rot_s       = rot_right(cand_s, commit_head);
    pick_any_s  = |rot_s;
    pick_slot_s = lowest_set(rot_s) + commit_head;
    pick_oh_s   = {{(NCOMMIT-1){1'b0}}, 1'b1} << pick_slot_s;
    kill_cur_s  = kill[idx_r];
  end

  // Next-state logic; kill of the owned slot always takes priority.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    abort_nxt_s = 1'b0;
    pick_en_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        pick_en_s = 1'b1;
        if (pick_any_s) begin
          state_nxt_s = S_REQ;
          idx_nxt_s   = pick_slot_s;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (kill_cur_s) begin
          state_nxt_s = S_IDLE;
          abort_nxt_s = issue_ack;
        end else if (issue_ack) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_RUN: begin
        if (kill_cur_s) begin
          state_nxt_s = S_IDLE;
          abort_nxt_s = 1'b1;
        end else if (div_done) begin
          state_nxt_s = S_WB;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_WB: begin
        if (kill_cur_s) begin
          state_nxt_s = S_IDLE;
        end else if (!wb_stall) begin
`ifdef DIV_SCHED_B2B_EN
          pick_en_s = 1'b1;
          if (pick_any_s) begin
            state_nxt_s = S_REQ;
            idx_nxt_s   = pick_slot_s;
          end else begin
            state_nxt_s = S_IDLE;
          end
`else
          state_nxt_s = S_IDLE;
`endif
        end else begin
          state_nxt_s = S_WB;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, owned slot and registered output decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      idx_r         <= {LNCOMMIT{1'b0}};
      issue_valid_r <= 1'b0;
      div_abort_r   <= 1'b0;
      wb_valid_r    <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      idx_r         <= idx_nxt_s;
      issue_valid_r <= (state_nxt_s == S_REQ);
      div_abort_r   <= abort_nxt_s;
      wb_valid_r    <= (state_nxt_s == S_WB);
      busy_r        <= (state_nxt_s != S_IDLE);
    end
  end

  // picked is gated by reset so it reads zero while reset is held.
  assign picked      = (pick_en_s && pick_any_s && reset) ? pick_oh_s : {NCOMMIT{1'b0}};
  assign issue_valid = issue_valid_r;
  assign issue_idx   = idx_r;
  assign div_abort   = div_abort_r;
  assign wb_valid    = wb_valid_r;
  assign wb_idx      = idx_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: expected issue slots are queued at pick time and checked at issue.
module tb_div_sched;

  logic        clk;
  logic        reset;
  logic [31:0] ready_mask;
  logic [4:0]  commit_head;
  logic [31:0] kill;
  logic        issue_valid;
  logic [4:0]  issue_idx;
  logic        issue_ack;
  logic        div_done;
  logic        div_abort;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic        wb_stall;
  logic [31:0] picked;
  logic        busy;

  int checks;
  int failures;
  int exp_q[$];

  div_sched #(.NCOMMIT(32), .LNCOMMIT(5)) dut (
    .clk(clk), .reset(reset), .ready_mask(ready_mask), .commit_head(commit_head),
    .kill(kill), .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ack(issue_ack),
    .div_done(div_done), .div_abort(div_abort), .wb_valid(wb_valid), .wb_idx(wb_idx),
    .wb_stall(wb_stall), .picked(picked), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pick: walk slots from head in age order.
  function automatic int model_pick(input logic [31:0] rdy, input logic [31:0] kl, input int head);
    for (int k = 0; k < 32; k++) begin
      int s;
      s = (head + k) % 32;
      if (rdy[s] && !kl[s]) return s;
    end
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pick(input logic [31:0] rdy, input logic [4:0] head);
    int m;
    ready_mask  = rdy;
    commit_head = head;
    m = model_pick(rdy, kill, int'(head));
    if (m >= 0) exp_q.push_back(m);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; ready_mask = 32'h5; commit_head = 5'd0; kill = 32'h0;
    issue_ack = 1'b0; div_done = 1'b0; wb_stall = 1'b0;
    tick; tick;
    checks++;
    if ({issue_valid, issue_idx, div_abort, wb_valid, busy} !== 9'd0 || picked !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: iv=%b idx=%0d ab=%b wb=%b busy=%b picked=%h, want all 0",
               issue_valid, issue_idx, div_abort, wb_valid, busy, picked);
    end
    ready_mask = 32'h0;
    reset = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0 || issue_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release: busy=%b iv=%b want 0 0", busy, issue_valid);
    end
  endtask

  task automatic test_basic;
    int e;
    drive_pick(32'h30, 5'd0);
    checks++;
    if (picked !== 32'h10) begin failures++; $display("FAIL basic_picked: got %h want 00000010", picked); end
    tick;
    ready_mask = 32'h0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++;
    if (issue_valid !== 1'b1 || int'(issue_idx) != e || e != 4) begin
      failures++; $display("FAIL basic_issue: iv=%b idx=%0d want 1 %0d", issue_valid, issue_idx, e);
    end
    tick;
    checks++;
    if (issue_valid !== 1'b1 || int'(issue_idx) != e) begin
      failures++; $display("FAIL basic_req_hold: iv=%b idx=%0d want 1 %0d", issue_valid, issue_idx, e);
    end
    issue_ack = 1'b1;
    tick;
    issue_ack = 1'b0;
    checks++;
    if (issue_valid !== 1'b0 || busy !== 1'b1 || wb_valid !== 1'b0) begin
      failures++; $display("FAIL basic_run: iv=%b busy=%b wb=%b want 0 1 0", issue_valid, busy, wb_valid);
    end
    div_done = 1'b1;
    tick;
    div_done = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_idx !== 5'd4) begin
      failures++; $display("FAIL basic_wb: wb=%b idx=%0d want 1 4", wb_valid, wb_idx);
    end
    tick;
    checks++;
    if (wb_valid !== 1'b0 || busy !== 1'b0 || div_abort !== 1'b0) begin
      failures++; $display("FAIL basic_idle: wb=%b busy=%b ab=%b want 0 0 0", wb_valid, busy, div_abort);
    end
  endtask

  task automatic test_wrap;
    logic [4:0]  heads [3];
    int          want  [3];
    int          e;
    logic [31:0] oh;
    heads = '{5'd30, 5'd2, 5'd1};
    want  = '{31, 31, 1};
    for (int i = 0; i < 3; i++) begin
      drive_pick(32'h8000_0002, heads[i]);
      oh = 32'h1 << want[i];
      checks++;
      if (picked !== oh) begin
        failures++; $display("FAIL wrap_picked head=%0d: got %h want %h", heads[i], picked, oh);
      end
      tick;
      ready_mask = 32'h0;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      checks++;
      if (issue_valid !== 1'b1 || int'(issue_idx) != want[i] || e != want[i]) begin
        failures++; $display("FAIL wrap_issue head=%0d: iv=%b idx=%0d model=%0d want %0d",
                             heads[i], issue_valid, issue_idx, e, want[i]);
      end
      kill = 32'h1 << want[i];
      tick;
      kill = 32'h0;
      checks++;
      if (busy !== 1'b0 || div_abort !== 1'b0 || issue_valid !== 1'b0) begin
        failures++; $display("FAIL wrap_req_kill: busy=%b ab=%b iv=%b want 0 0 0", busy, div_abort, issue_valid);
      end
    end
    commit_head = 5'd0;
  endtask

  task automatic test_req_kill_ack;
    int e;
    drive_pick(32'h80, 5'd0);
    tick;
    ready_mask = 32'h0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++;
    if (issue_valid !== 1'b1 || int'(issue_idx) != e || e != 7) begin
      failures++; $display("FAIL rk_issue: iv=%b idx=%0d want 1 7", issue_valid, issue_idx);
    end
    issue_ack = 1'b1; kill = 32'h80;
    tick;
    issue_ack = 1'b0; kill = 32'h0;
    checks++;
    if (div_abort !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0 || issue_valid !== 1'b0) begin
      failures++; $display("FAIL rk_abort: ab=%b busy=%b wb=%b iv=%b want 1 0 0 0", div_abort, busy, wb_valid, issue_valid);
    end
    tick;
    checks++;
    if (div_abort !== 1'b0 || wb_valid !== 1'b0) begin
      failures++; $display("FAIL rk_abort_len: ab=%b wb=%b want 0 0", div_abort, wb_valid);
    end
  endtask

  task automatic test_run_kill_done;
    int e;
    drive_pick(32'h200, 5'd0);
    tick;
    ready_mask = 32'h0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++;
    if (issue_valid !== 1'b1 || int'(issue_idx) != e || e != 9) begin
      failures++; $display("FAIL rd_issue: iv=%b idx=%0d want 1 9", issue_valid, issue_idx);
    end
    issue_ack = 1'b1;
    tick;
    issue_ack = 1'b0; kill = 32'h1;
    tick;
    kill = 32'h0;
    checks++;
    if (busy !== 1'b1 || div_abort !== 1'b0 || wb_valid !== 1'b0) begin
      failures++; $display("FAIL rd_other_kill: busy=%b ab=%b wb=%b want 1 0 0", busy, div_abort, wb_valid);
    end
    div_done = 1'b1; kill = 32'h200;
    tick;
    div_done = 1'b0; kill = 32'h0;
    checks++;
    if (div_abort !== 1'b1 || wb_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rd_abort: ab=%b wb=%b busy=%b want 1 0 0", div_abort, wb_valid, busy);
    end
    tick;
    checks++;
    if (div_abort !== 1'b0 || wb_valid !== 1'b0) begin
      failures++; $display("FAIL rd_after: ab=%b wb=%b want 0 0", div_abort, wb_valid);
    end
  endtask

  task automatic test_wb_stall;
    int          e;
    logic [31:0] want_pick;
    drive_pick(32'h8, 5'd0);
    tick;
    ready_mask = 32'h0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++;
    if (issue_valid !== 1'b1 || int'(issue_idx) != e || e != 3) begin
      failures++; $display("FAIL ws_issue: iv=%b idx=%0d want 1 3", issue_valid, issue_idx);
    end
    issue_ack = 1'b1;
    tick;
    issue_ack = 1'b0; div_done = 1'b1; wb_stall = 1'b1;
    tick;
    div_done = 1'b0; ready_mask = 32'h20;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) wb_stall = 1'b0;
      #1;
`ifdef DIV_SCHED_B2B_EN
      want_pick = (c == 4) ? 32'h20 : 32'h0;
`else
      want_pick = 32'h0;
`endif
      checks++;
      if (wb_valid !== 1'b1 || wb_idx !== 5'd3 || picked !== want_pick) begin
        failures++; $display("FAIL ws_hold c=%0d: wb=%b idx=%0d picked=%h want 1 3 %h", c, wb_valid, wb_idx, picked, want_pick);
      end
      tick;
    end
    exp_q.push_back(5);
    checks++;
    if (wb_valid !== 1'b0) begin failures++; $display("FAIL ws_drop: wb=%b want 0", wb_valid); end
`ifndef DIV_SCHED_B2B_EN
    checks++;
    if (busy !== 1'b0 || picked !== 32'h20) begin
      failures++; $display("FAIL ws_idle: busy=%b picked=%h want 0 00000020", busy, picked);
    end
    tick;
`endif
    ready_mask = 32'h0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++;
    if (issue_valid !== 1'b1 || int'(issue_idx) != e) begin
      failures++; $display("FAIL ws_next_issue: iv=%b idx=%0d want 1 %0d", issue_valid, issue_idx, e);
    end
    kill = 32'h20;
    tick;
    kill = 32'h0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ws_cleanup: busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset;
    int e;
    drive_pick(32'h1000, 5'd0);
    tick;
    ready_mask = 32'h0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    issue_ack = 1'b1;
    tick;
    issue_ack = 1'b0;
    checks++;
    if (busy !== 1'b1 || int'(issue_idx) != e || e != 12) begin
      failures++; $display("FAIL ar_run: busy=%b idx=%0d want 1 12", busy, issue_idx);
    end
    ready_mask = 32'h1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({issue_valid, issue_idx, div_abort, wb_valid, busy} !== 9'd0 || picked !== 32'h0) begin
      failures++;
      $display("FAIL ar_async: iv=%b idx=%0d ab=%b wb=%b busy=%b picked=%h want all 0",
               issue_valid, issue_idx, div_abort, wb_valid, busy, picked);
    end
    tick; tick;
    reset = 1'b1;
    drive_pick(32'h1, 5'd0);
    checks++;
    if (picked !== 32'h1 || div_abort !== 1'b0) begin
      failures++; $display("FAIL ar_pick: picked=%h ab=%b want 00000001 0", picked, div_abort);
    end
    tick;
    ready_mask = 32'h0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    checks++;
    if (issue_valid !== 1'b1 || int'(issue_idx) != e || e != 0 || div_abort !== 1'b0) begin
      failures++; $display("FAIL ar_issue: iv=%b idx=%0d ab=%b want 1 0 0", issue_valid, issue_idx, div_abort);
    end
    kill = 32'h1;
    tick;
    kill = 32'h0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_basic;
    test_wrap;
    test_req_kill_ack;
    test_run_kill_done;
    test_wb_stall;
    test_async_reset;
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_empty: %0d left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
